// File: rtl/conv_mac_datapath_pkg.sv
// Shared definitions for the convolution accelerator: widths, ctrl word layout
// and the output saturation helper. Used by both the controller and the datapath.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 16;
  localparam int N_TAPS = 16;
  localparam int CTRL_W = 5;

  // The pixel is zero-extended by one bit so the product is a signed multiply.
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = PROD_W + 4;

  localparam int CTRL_MULT = 4;
  localparam int CTRL_L1   = 3;
  localparam int CTRL_L2   = 2;
  localparam int CTRL_L3   = 1;
  localparam int CTRL_L4   = 0;

  typedef enum logic [CTRL_W-1:0] {
    PH_IDLE = 5'b00000,
    PH_MULT = 5'b10000,
    PH_L1   = 5'b01000,
    PH_L2   = 5'b00100,
    PH_L3   = 5'b00010,
    PH_L4   = 5'b00001
  } phase_e;

  typedef struct packed {
    logic             clip;
    logic [OUT_W-1:0] value;
  } sat_t;

  function automatic sat_t saturate(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] sum_max;
    logic signed [SUM_W-1:0] sum_min;
    sat_t s;
    sum_max = SUM_W'(2 ** (OUT_W - 1) - 1);
    sum_min = ~sum_max;
    s.clip  = 1'b0;
    s.value = sum[OUT_W-1:0];
    if (sum > sum_max) begin
      s.clip  = 1'b1;
      s.value = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (sum < sum_min) begin
      s.clip  = 1'b1;
      s.value = {1'b1, {(OUT_W-1){1'b0}}};
    end
    return s;
  endfunction

endpackage

// File: rtl/conv_mac_datapath_if.sv
// Link between the accelerator controller (master) and the MAC datapath (slave).
interface conv_mac_datapath_if;
  import conv_pkg::*;

  // load_valid qualifies pix_in/coef_in for one cycle and has no ready: a sample
  // is taken only while ctrl is idle, otherwise it is dropped and err is raised.
  // result_valid is a one-cycle pulse; result and sat_flag hold until the next one.
  logic              load_valid;
  logic [DATA_W-1:0] pix_in;
  logic [COEF_W-1:0] coef_in;
  logic [CTRL_W-1:0] ctrl;
  logic [OUT_W-1:0]  result;
  logic              result_valid;
  logic              sat_flag;
  logic              taps_full;
  logic              err;

  modport master (
    output load_valid, pix_in, coef_in, ctrl,
    input  result, result_valid, sat_flag, taps_full, err
  );

  modport slave (
    input  load_valid, pix_in, coef_in, ctrl,
    output result, result_valid, sat_flag, taps_full, err
  );
endinterface

// File: rtl/conv_adder_level.sv
// One registered level of the reduction tree: N_IN signed words of IN_W bits
// are summed pairwise into N_IN/2 words of IN_W+1 bits when enabled.
module conv_adder_level #(
  parameter int IN_W = 17,
  parameter int N_IN = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [N_IN*IN_W-1:0]          din,
  output logic [(N_IN/2)*(IN_W+1)-1:0]  dout
);
  localparam int SW    = IN_W + 1;
  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*SW-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum_c[j*SW +: SW] = SW'($signed(din[(2*j)*IN_W +: IN_W]))
                        + SW'($signed(din[(2*j+1)*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) dout <= '0;
    else if (en) dout <= sum_c;
  end
endmodule

// File: rtl/conv_mac_datapath.sv
// 16-tap convolution MAC: serial tap load, registered products, 4-level
// registered adder tree, saturated result with a one-cycle valid pulse.
module conv_mac_datapath
  import conv_pkg::*;
(
  input logic                clk,
  input logic                reset,
  conv_mac_datapath_if.slave bus
);
  logic [DATA_W-1:0]        pix_tap  [N_TAPS];
  logic [COEF_W-1:0]        coef_tap [N_TAPS];
  logic [N_TAPS*PROD_W-1:0] prod_c;
  logic [N_TAPS*PROD_W-1:0] prod;
  logic [8*(PROD_W+1)-1:0]  lvl1;
  logic [4*(PROD_W+2)-1:0]  lvl2;
  logic [2*(PROD_W+3)-1:0]  lvl3;
  logic [SUM_W-1:0]         lvl4;
  logic [4:0]               load_count;
  logic                     l4_d;
  logic [OUT_W-1:0]         result_q;
  logic                     result_valid_q;
  logic                     sat_flag_q;
  logic                     err_q;
  logic                     full;
  sat_t                     sat;

  // A multi-hot ctrl word matches none of the exact phase encodings below,
  // so it blocks every tap, product and level update on its own.
  wire legal    = $onehot0(bus.ctrl);
  wire idle     = (bus.ctrl == PH_IDLE);
  wire load_acc = bus.load_valid && idle;
  wire mult_en  = (bus.ctrl == PH_MULT);
  wire capture  = l4_d && !bus.ctrl[CTRL_L4];

  assign full = (load_count == 5'(N_TAPS));
  assign sat  = saturate(lvl4);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        pix_tap[i]  <= '0;
        coef_tap[i] <= '0;
      end
    end else if (load_acc) begin
      pix_tap[0]  <= bus.pix_in;
      coef_tap[0] <= bus.coef_in;
      for (int i = 1; i < N_TAPS; i++) begin
        pix_tap[i]  <= pix_tap[i-1];
        coef_tap[i] <= coef_tap[i-1];
      end
    end
  end

  always_comb begin
    prod_c = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      prod_c[i*PROD_W +: PROD_W] = PROD_W'($signed({1'b0, pix_tap[i]}))
                                 * PROD_W'($signed(coef_tap[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) prod <= '0;
    else if (mult_en) prod <= prod_c;
  end

  conv_adder_level #(.IN_W(PROD_W),   .N_IN(16)) u_l1 (
    .clk(clk), .reset(reset), .en(bus.ctrl == PH_L1), .din(prod), .dout(lvl1));
  conv_adder_level #(.IN_W(PROD_W+1), .N_IN(8))  u_l2 (
    .clk(clk), .reset(reset), .en(bus.ctrl == PH_L2), .din(lvl1), .dout(lvl2));
  conv_adder_level #(.IN_W(PROD_W+2), .N_IN(4))  u_l3 (
    .clk(clk), .reset(reset), .en(bus.ctrl == PH_L3), .din(lvl2), .dout(lvl3));
  conv_adder_level #(.IN_W(PROD_W+3), .N_IN(2))  u_l4 (
    .clk(clk), .reset(reset), .en(bus.ctrl == PH_L4), .din(lvl3), .dout(lvl4));

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sat_flag_q     <= 1'b0;
      err_q          <= 1'b0;
      load_count     <= '0;
      l4_d           <= 1'b0;
    end else begin
      l4_d           <= bus.ctrl[CTRL_L4];
      result_valid_q <= capture;
      if (capture) begin
        result_q   <= sat.value;
        sat_flag_q <= sat.clip;
      end
      if (!legal || (bus.load_valid && !idle) || (mult_en && !full)) err_q <= 1'b1;
      // The window clear wins; a load in the same cycle starts the next window.
      if (capture) load_count <= load_acc ? 5'd1 : 5'd0;
      else if (load_acc && !full) load_count <= load_count + 5'd1;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.sat_flag     = sat_flag_q;
  assign bus.taps_full    = full;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_conv_mac_datapath.sv
// Directed bench for conv_mac_datapath: window-level reference model with a
// per-cycle compare process plus literal expectations for each scenario.
module tb_conv_mac_datapath;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_mac_datapath_if bus ();
  conv_mac_datapath dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Reference model: last 16 accepted samples, window sum taken while MULT runs.
  int               m_pix  [N_TAPS];
  int               m_coef [N_TAPS];
  int               m_count = 0;
  int               m_snap = 0;
  logic [OUT_W-1:0] m_result = '0;
  logic             m_sat = 1'b0;
  logic             m_valid = 1'b0;
  logic             m_err = 1'b0;
  logic             m_l4_d = 1'b0;
  logic [4:0]       m_ctrl;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        m_pix[i]  = 0;
        m_coef[i] = 0;
      end
      m_count = 0; m_snap = 0; m_result = '0; m_sat = 0;
      m_valid = 0; m_err = 0; m_l4_d = 0;
      exp_q.delete();
    end else begin
      m_ctrl  = bus.ctrl;
      m_valid = 1'b0;
      if ($countones(m_ctrl) > 1) m_err = 1'b1;
      if (bus.load_valid && m_ctrl != 5'b0) m_err = 1'b1;
      if (m_ctrl == 5'b10000) begin
        if (m_count != 16) m_err = 1'b1;
        m_snap = 0;
        for (int i = 0; i < N_TAPS; i++) m_snap += m_pix[i] * m_coef[i];
      end
      if (m_l4_d && !m_ctrl[0]) begin
        if (m_snap > 32767) begin m_result = 16'h7fff; m_sat = 1'b1; end
        else if (m_snap < -32768) begin m_result = 16'h8000; m_sat = 1'b1; end
        else begin m_result = 16'(m_snap); m_sat = 1'b0; end
        exp_q.push_back(m_result);
        m_valid = 1'b1;
        m_count = 0;
      end
      if (bus.load_valid && m_ctrl == 5'b0) begin
        for (int i = N_TAPS - 1; i > 0; i--) begin
          m_pix[i]  = m_pix[i-1];
          m_coef[i] = m_coef[i-1];
        end
        m_pix[0]  = int'(bus.pix_in);
        m_coef[0] = int'($signed(bus.coef_in));
        if (m_count < 16) m_count++;
      end
      m_l4_d = m_ctrl[0];
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_result", 32'(bus.result), 32'(m_result));
      check("cyc_valid", 32'(bus.result_valid), 32'(m_valid));
      check("cyc_sat", 32'(bus.sat_flag), 32'(m_sat));
      check("cyc_full", 32'(bus.taps_full), 32'(m_count == 16));
      check("cyc_err", 32'(bus.err), 32'(m_err));
      if (bus.result_valid === 1'b1) begin
        if (exp_q.size() == 0) check("sb_unexpected_result", 32'(bus.result), 32'hffff_ffff);
        else begin
          exp_v = exp_q.pop_front();
          check("sb_result", 32'(bus.result), 32'(exp_v));
        end
      end
    end
  end

  task automatic drive(input logic lv, input logic [7:0] p, input logic [7:0] c,
                       input logic [4:0] ct);
    @(negedge clk);
    bus.load_valid = lv;
    bus.pix_in     = p;
    bus.coef_in    = c;
    bus.ctrl       = ct;
  endtask

  task automatic run_phases(input bit bad_ctrl, input bit bad_load);
    for (int i = 0; i < 16; i++) begin
      if (bad_load && i == 3) drive(1'b1, 8'd100, 8'd100, PH_MULT);
      else drive(1'b0, 8'd0, 8'd0, PH_MULT);
      if (bad_load && i == 4) begin
        check("load_in_mult_err", 32'(bus.err), 32'd1);
        check("load_in_mult_full", 32'(bus.taps_full), 32'd1);
      end
    end
    if (bad_ctrl) begin
      drive(1'b0, 8'd0, 8'd0, 5'b11000);
      drive(1'b0, 8'd0, 8'd0, PH_L1);
      check("illegal_ctrl_err", 32'(bus.err), 32'd1);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 8'd0, 8'd0, PH_L1);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'd0, 8'd0, PH_L2);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'd0, 8'd0, PH_L3);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'd0, 8'd0, PH_L4);
    drive(1'b0, 8'd0, 8'd0, PH_IDLE);
  endtask

  task automatic wait_result(input string name, input logic [15:0] exp_r, input logic exp_s);
    bit seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) seen = 1'b1;
    end
    check({name, "_valid_seen"}, 32'(seen), 32'd1);
    check({name, "_result"}, 32'(bus.result), 32'(exp_r));
    check({name, "_model"}, 32'(m_result), 32'(exp_r));
    check({name, "_sat"}, 32'(bus.sat_flag), 32'(exp_s));
    @(negedge clk);
    check({name, "_pulse_end"}, 32'(bus.result_valid), 32'd0);
    check({name, "_full_clr"}, 32'(bus.taps_full), 32'd0);
  endtask

  task automatic load_const(input logic [7:0] p, input logic [7:0] c);
    for (int i = 0; i < 16; i++) drive(1'b1, p, c, PH_IDLE);
    drive(1'b0, 8'd0, 8'd0, PH_IDLE);
  endtask

  task automatic load_mixed();
    for (int i = 0; i < 16; i++)
      drive(1'b1, 8'(i + 1), (i % 2 == 0) ? 8'd2 : 8'hff, PH_IDLE);
    drive(1'b0, 8'd0, 8'd0, PH_IDLE);
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 8'd0, PH_IDLE);
    reset = 1'b0;
    repeat (3) drive(1'b0, 8'd0, 8'd0, PH_IDLE);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.pix_in     = '0;
    bus.coef_in    = '0;
    bus.ctrl       = '0;
    repeat (3) drive(1'b0, 8'd0, 8'd0, PH_IDLE);
    check_en = 1'b1;
    reset = 1'b1;

    load_const(8'd1, 8'd1);
    check("basic_full", 32'(bus.taps_full), 32'd1);
    run_phases(1'b0, 1'b0);
    wait_result("basic", 16'd16, 1'b0);

    load_const(8'd255, 8'h80);
    run_phases(1'b0, 1'b0);
    wait_result("neg_sat", 16'h8000, 1'b1);

    for (int i = 0; i < 5; i++) drive(1'b1, 8'd9, 8'd3, PH_IDLE);
    do_reset();
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_sat", 32'(bus.sat_flag), 32'd0);
    check("rst_full", 32'(bus.taps_full), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b1;

    load_mixed();
    run_phases(1'b0, 1'b0);
    wait_result("mixed", 16'd56, 1'b0);

    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i + 1), 8'd1, PH_IDLE);
    drive(1'b0, 8'd0, 8'd0, PH_IDLE);
    check("overflow_full", 32'(bus.taps_full), 32'd1);
    run_phases(1'b0, 1'b0);
    wait_result("overflow", 16'd200, 1'b0);

    load_const(8'd1, 8'd1);
    check("pre_illegal_err", 32'(bus.err), 32'd0);
    run_phases(1'b1, 1'b0);
    wait_result("illegal", 16'd16, 1'b0);

    do_reset();
    reset = 1'b1;
    load_mixed();
    check("pre_load_err", 32'(bus.err), 32'd0);
    run_phases(1'b0, 1'b1);
    wait_result("load_in_mult", 16'd56, 1'b0);

    repeat (3) drive(1'b0, 8'd0, 8'd0, PH_IDLE);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
